// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus hub.
package bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } hub_state_t;

   // Request fields that must survive past the IDLE cycle.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              is_wr;
   } host_req_t;

endpackage

// File: rtl/bus_addr_decoder.sv
// Priority address decoder: lowest matching device index wins on overlap.
module bus_addr_decoder
   import bus_pkg::*;
#(
   parameter int unsigned N_DEV = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [ADDR_W-1:0]       addr_i,
   input  logic [N_DEV*ADDR_W-1:0] dev_base_i,
   input  logic [N_DEV*ADDR_W-1:0] dev_mask_i,
   output logic                    hit_o,
   output logic [IDX_W-1:0]        index_o,
   output logic [N_DEV-1:0]        sel_o
);

   // Scan from the top so the lowest matching index is written last.
   always_comb begin
      hit_o   = 1'b0;
      index_o = '0;
      sel_o   = '0;
      for (int i = N_DEV - 1; i >= 0; i--) begin
         if ((addr_i & dev_mask_i[i*ADDR_W +: ADDR_W]) == dev_base_i[i*ADDR_W +: ADDR_W]) begin
            hit_o    = 1'b1;
            index_o  = IDX_W'(i);
            sel_o    = '0;
            sel_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_hub_n.sv
// N-device bus hub: decodes the host request, runs one registered transaction
// at a time through IDLE/BUSY/RESP, and turns unmapped or hung accesses into
// error responses.
module bus_hub_n
   import bus_pkg::*;
#(
   parameter int unsigned              N_DEV    = 4,
   parameter logic [N_DEV*ADDR_W-1:0]  DEV_BASE = {N_DEV{32'h0}},
   parameter logic [N_DEV*ADDR_W-1:0]  DEV_MASK = {N_DEV{32'hFFFF_0000}},
   parameter int unsigned              TIMEOUT  = 255,
   parameter logic [DATA_W-1:0]        ERR_DATA = ERR_DATA_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_W-1:0]       host_address,
   input  logic [DATA_W-1:0]       host_data_write,
   input  logic [MASK_W-1:0]       host_write_mask,
   input  logic                    host_wen,
   input  logic                    host_ren,
   output logic [DATA_W-1:0]       host_data_read,
   output logic                    host_ready,
   output logic                    host_error,
   output logic [N_DEV*ADDR_W-1:0] device_address,
   output logic [N_DEV*DATA_W-1:0] device_data_write,
   output logic [N_DEV*MASK_W-1:0] device_write_mask,
   output logic [N_DEV-1:0]        device_wen,
   output logic [N_DEV-1:0]        device_ren,
   input  logic [N_DEV-1:0]        device_ready,
   input  logic [N_DEV*DATA_W-1:0] device_data_read,
   output logic [N_DEV-1:0]        device_active,
   output logic [15:0]             err_count,
   output logic [ADDR_W-1:0]       last_err_addr
);

   localparam int unsigned IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

   hub_state_t state_q, state_d;

   host_req_t               req_q, req_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    ready_q, ready_d;
   logic                    error_q, error_d;
   logic [N_DEV*ADDR_W-1:0] dev_addr_q, dev_addr_d;
   logic [N_DEV*DATA_W-1:0] dev_wdata_q, dev_wdata_d;
   logic [N_DEV*MASK_W-1:0] dev_wmask_q, dev_wmask_d;
   logic [N_DEV-1:0]        dev_wen_q, dev_wen_d;
   logic [N_DEV-1:0]        dev_ren_q, dev_ren_d;
   logic [N_DEV-1:0]        dev_active_q, dev_active_d;
   logic [15:0]             err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0]       last_err_q, last_err_d;

   logic                    req_c;
   logic                    dec_hit_c;
   logic [IDX_W-1:0]        dec_idx_c;
   logic [N_DEV-1:0]        dec_sel_c;
   logic                    sel_ready_c;
   logic [DATA_W-1:0]       sel_rdata_c;
   logic                    timeout_c;
   logic                    err_evt_c;
   logic [ADDR_W-1:0]       err_addr_c;

   bus_addr_decoder #(
      .N_DEV (N_DEV),
      .IDX_W (IDX_W)
   ) u_decoder (
      .addr_i     (host_address),
      .dev_base_i (DEV_BASE),
      .dev_mask_i (DEV_MASK),
      .hit_o      (dec_hit_c),
      .index_o    (dec_idx_c),
      .sel_o      (dec_sel_c)
   );

   // Request, selected-device handshake and watchdog expiry.
   always_comb begin
      req_c       = host_ren | host_wen;
      sel_ready_c = device_ready[idx_q];
      sel_rdata_c = device_data_read[32'(idx_q)*DATA_W +: DATA_W];
      timeout_c   = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_c) state_d = dec_hit_c ? BUSY : RESP;
         BUSY: if (sel_ready_c || timeout_c) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output/datapath next values; strobes live only while in BUSY.
   always_comb begin
      req_d        = req_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      ready_d      = 1'b0;
      error_d      = 1'b0;
      dev_addr_d   = dev_addr_q;
      dev_wdata_d  = dev_wdata_q;
      dev_wmask_d  = '0;
      dev_wen_d    = '0;
      dev_ren_d    = '0;
      dev_active_d = '0;
      err_cnt_d    = err_cnt_q;
      last_err_d   = last_err_q;
      err_evt_c    = 1'b0;
      err_addr_c   = '0;

      case (state_q)
         IDLE: begin
            if (req_c) begin
               req_d.addr  = host_address;
               req_d.is_wr = host_wen;
               idx_d       = dec_idx_c;
               cnt_d       = '0;
               dev_wdata_d = {N_DEV{host_data_write}};
               for (int i = 0; i < N_DEV; i++) begin
                  dev_addr_d[i*ADDR_W +: ADDR_W] = host_address & ~DEV_MASK[i*ADDR_W +: ADDR_W];
               end
               if (dec_hit_c) begin
                  dev_active_d = dec_sel_c;
                  dev_wen_d    = host_wen ? dec_sel_c : '0;
                  dev_ren_d    = host_wen ? '0 : dec_sel_c;
                  for (int i = 0; i < N_DEV; i++) begin
                     if (dec_sel_c[i]) dev_wmask_d[i*MASK_W +: MASK_W] = host_write_mask;
                  end
               end else begin
                  ready_d    = 1'b1;
                  error_d    = 1'b1;
                  rdata_d    = ERR_DATA;
                  err_evt_c  = 1'b1;
                  err_addr_c = host_address;
               end
            end
         end
         BUSY: begin
            if (sel_ready_c) begin
               ready_d = 1'b1;
               rdata_d = req_q.is_wr ? '0 : sel_rdata_c;
            end else if (timeout_c) begin
               ready_d    = 1'b1;
               error_d    = 1'b1;
               rdata_d    = ERR_DATA;
               err_evt_c  = 1'b1;
               err_addr_c = req_q.addr;
            end else begin
               dev_wmask_d  = dev_wmask_q;
               dev_wen_d    = dev_wen_q;
               dev_ren_d    = dev_ren_q;
               dev_active_d = dev_active_q;
               cnt_d        = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase

      if (err_evt_c) begin
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
         last_err_d = err_addr_c;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         error_q      <= 1'b0;
         dev_addr_q   <= '0;
         dev_wdata_q  <= '0;
         dev_wmask_q  <= '0;
         dev_wen_q    <= '0;
         dev_ren_q    <= '0;
         dev_active_q <= '0;
         err_cnt_q    <= '0;
         last_err_q   <= '0;
      end else begin
         req_q        <= req_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         error_q      <= error_d;
         dev_addr_q   <= dev_addr_d;
         dev_wdata_q  <= dev_wdata_d;
         dev_wmask_q  <= dev_wmask_d;
         dev_wen_q    <= dev_wen_d;
         dev_ren_q    <= dev_ren_d;
         dev_active_q <= dev_active_d;
         err_cnt_q    <= err_cnt_d;
         last_err_q   <= last_err_d;
      end
   end

   assign host_data_read    = rdata_q;
   assign host_ready        = ready_q;
   assign host_error        = error_q;
   assign device_address    = dev_addr_q;
   assign device_data_write = dev_wdata_q;
   assign device_write_mask = dev_wmask_q;
   assign device_wen        = dev_wen_q;
   assign device_ren        = dev_ren_q;
   assign device_active     = dev_active_q;
   assign err_count         = err_cnt_q;
   assign last_err_addr     = last_err_q;

endmodule

// File: tb/tb_bus_hub_n.sv
// Directed bench for bus_hub_n with four devices and an 8-cycle watchdog.
module tb_bus_hub_n;

   localparam int N = 4;
   localparam logic [N*32-1:0] BASES = {32'h0000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
   localparam logic [N*32-1:0] MASKS = {32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

   logic            clk;
   logic            rst;
   logic [31:0]     host_address;
   logic [31:0]     host_data_write;
   logic [3:0]      host_write_mask;
   logic            host_wen;
   logic            host_ren;
   logic [31:0]     host_data_read;
   logic            host_ready;
   logic            host_error;
   logic [N*32-1:0] device_address;
   logic [N*32-1:0] device_data_write;
   logic [N*4-1:0]  device_write_mask;
   logic [N-1:0]    device_wen;
   logic [N-1:0]    device_ren;
   logic [N-1:0]    device_ready;
   logic [N*32-1:0] device_data_read;
   logic [N-1:0]    device_active;
   logic [15:0]     err_count;
   logic [31:0]     last_err_addr;

   int checks   = 0;
   int failures = 0;

   // Per-cycle observations of the latest transaction.
   logic [3:0]      sn_ren [0:31];
   logic [3:0]      sn_wen [0:31];
   logic [3:0]      sn_act [0:31];
   logic [15:0]     sn_msk [0:31];
   logic [N*32-1:0] c1_daddr;
   logic [N*32-1:0] c1_dwdata;
   int              got_cyc;
   logic [31:0]     got_data;
   logic            got_err;
   logic [3:0]      noise;

   bus_hub_n #(
      .N_DEV    (N),
      .DEV_BASE (BASES),
      .DEV_MASK (MASKS),
      .TIMEOUT  (8),
      .ERR_DATA (32'hDEAD_BEEF)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .host_address      (host_address),
      .host_data_write   (host_data_write),
      .host_write_mask   (host_write_mask),
      .host_wen          (host_wen),
      .host_ren          (host_ren),
      .host_data_read    (host_data_read),
      .host_ready        (host_ready),
      .host_error        (host_error),
      .device_address    (device_address),
      .device_data_write (device_data_write),
      .device_write_mask (device_write_mask),
      .device_wen        (device_wen),
      .device_ren        (device_ren),
      .device_ready      (device_ready),
      .device_data_read  (device_data_read),
      .device_active     (device_active),
      .err_count         (err_count),
      .last_err_addr     (last_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request at a negedge; cycle c is the interval after the c-th edge.
   // A device answers in cycle rdy_cyc; ends in the IDLE cycle after the response.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m,
                          input logic we, input logic re, input int dev, input int rdy_cyc,
                          input logic [31:0] rd, input int budget);
      host_address    = addr;
      host_data_write = wd;
      host_write_mask = m;
      host_wen        = we;
      host_ren        = re;
      got_cyc  = -1;
      got_data = '0;
      got_err  = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (c < 32) begin
            sn_ren[c] = device_ren;
            sn_wen[c] = device_wen;
            sn_act[c] = device_active;
            sn_msk[c] = device_write_mask;
         end
         if (c == 1) begin
            c1_daddr  = device_address;
            c1_dwdata = device_data_write;
         end
         if (host_ready === 1'b1) begin
            got_cyc  = c;
            got_data = host_data_read;
            got_err  = host_error;
            break;
         end
         device_ready = noise;
         if (dev >= 0 && c == rdy_cyc) begin
            device_ready[dev] = 1'b1;
            device_data_read[dev*32 +: 32] = rd;
         end
      end
      host_wen     = 1'b0;
      host_ren     = 1'b0;
      device_ready = '0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL reset_host_ready got=%0h exp=0", host_ready); end
      checks++; if (host_error !== 1'b0) begin failures++; $display("FAIL reset_host_error got=%0h exp=0", host_error); end
      checks++; if (host_data_read !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", host_data_read); end
      checks++; if ({device_wen, device_ren, device_active} !== 12'h0) begin failures++; $display("FAIL reset_strobes got=%0h exp=0", {device_wen, device_ren, device_active}); end
      checks++; if (device_address !== '0) begin failures++; $display("FAIL reset_dev_addr got=%0h exp=0", device_address); end
      checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count got=%0h exp=0", err_count); end
      checks++; if (last_err_addr !== 32'h0) begin failures++; $display("FAIL reset_last_err got=%0h exp=0", last_err_addr); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_wait();
      noise = 4'b0101;
      run_txn(32'h0001_0004, 32'h0, 4'h0, 1'b0, 1'b1, 1, 4, 32'h1234_5678, 20);
      noise = 4'b0000;
      checks++; if (got_cyc !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", got_cyc); end
      checks++; if (got_data !== 32'h1234_5678) begin failures++; $display("FAIL rd_data got=%0h exp=12345678", got_data); end
      checks++; if (got_err !== 1'b0) begin failures++; $display("FAIL rd_error got=%0h exp=0", got_err); end
      checks++; if (c1_daddr[63:32] !== 32'h4) begin failures++; $display("FAIL rd_dev1_offset got=%0h exp=4", c1_daddr[63:32]); end
      checks++; if (sn_ren[1] !== 4'b0010) begin failures++; $display("FAIL rd_ren_c1 got=%b exp=0010", sn_ren[1]); end
      checks++; if (sn_ren[4] !== 4'b0010) begin failures++; $display("FAIL rd_ren_c4 got=%b exp=0010", sn_ren[4]); end
      checks++; if (sn_act[1] !== 4'b0010) begin failures++; $display("FAIL rd_active got=%b exp=0010", sn_act[1]); end
      checks++; if (sn_wen[1] !== 4'b0000) begin failures++; $display("FAIL rd_wen got=%b exp=0000", sn_wen[1]); end
   endtask

   task automatic test_write();
      run_txn(32'h0000_0010, 32'hA5A5_A5A5, 4'b0011, 1'b1, 1'b0, 0, 1, 32'hFFFF_FFFF, 10);
      checks++; if (got_cyc !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", got_cyc); end
      checks++; if (got_err !== 1'b0) begin failures++; $display("FAIL wr_error got=%0h exp=0", got_err); end
      checks++; if (got_data !== 32'h0) begin failures++; $display("FAIL wr_rdata got=%0h exp=0", got_data); end
      checks++; if (sn_wen[1] !== 4'b0001) begin failures++; $display("FAIL wr_wen got=%b exp=0001", sn_wen[1]); end
      checks++; if (sn_ren[1] !== 4'b0000) begin failures++; $display("FAIL wr_ren got=%b exp=0000", sn_ren[1]); end
      checks++; if (sn_msk[1] !== 16'h0003) begin failures++; $display("FAIL wr_mask got=%h exp=0003", sn_msk[1]); end
      checks++; if (c1_dwdata[31:0] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL wr_wdata got=%h exp=a5a5a5a5", c1_dwdata[31:0]); end
      checks++; if (c1_daddr[31:0] !== 32'h10) begin failures++; $display("FAIL wr_offset got=%h exp=10", c1_daddr[31:0]); end
      checks++; if ({sn_wen[2], sn_msk[2]} !== 20'h0) begin failures++; $display("FAIL wr_resp_strobes got=%h exp=0", {sn_wen[2], sn_msk[2]}); end
      // Read and write requested together behave as a write.
      run_txn(32'h0001_0020, 32'h0000_00FF, 4'b1111, 1'b1, 1'b1, 1, 1, 32'h5555_5555, 10);
      checks++; if ({sn_wen[1], sn_ren[1]} !== 8'b0010_0000) begin failures++; $display("FAIL rw_strobes got=%b exp=00100000", {sn_wen[1], sn_ren[1]}); end
      checks++; if (got_data !== 32'h0) begin failures++; $display("FAIL rw_rdata got=%h exp=0", got_data); end
   endtask

   task automatic test_unmapped();
      run_txn(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b1, -1, 0, 32'h0, 10);
      checks++; if (got_cyc !== 1) begin failures++; $display("FAIL um_latency got=%0d exp=1", got_cyc); end
      checks++; if (got_err !== 1'b1) begin failures++; $display("FAIL um_error got=%0h exp=1", got_err); end
      checks++; if (got_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL um_data got=%h exp=deadbeef", got_data); end
      checks++; if ({sn_ren[1], sn_act[1]} !== 8'h0) begin failures++; $display("FAIL um_strobes got=%h exp=0", {sn_ren[1], sn_act[1]}); end
      checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL um_err_count got=%0d exp=1", err_count); end
      checks++; if (last_err_addr !== 32'h8000_0000) begin failures++; $display("FAIL um_last_err got=%h exp=80000000", last_err_addr); end
   endtask

   task automatic test_timeout();
      run_txn(32'h0002_0008, 32'h0, 4'h0, 1'b0, 1'b1, 2, 0, 32'h0, 20);
      checks++; if (got_cyc !== 9) begin failures++; $display("FAIL to_latency got=%0d exp=9", got_cyc); end
      checks++; if (got_err !== 1'b1) begin failures++; $display("FAIL to_error got=%0h exp=1", got_err); end
      checks++; if (got_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_data got=%h exp=deadbeef", got_data); end
      checks++; if (sn_ren[8] !== 4'b0100) begin failures++; $display("FAIL to_ren_c8 got=%b exp=0100", sn_ren[8]); end
      checks++; if (sn_ren[9] !== 4'b0000) begin failures++; $display("FAIL to_ren_c9 got=%b exp=0000", sn_ren[9]); end
      checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL to_err_count got=%0d exp=2", err_count); end
      checks++; if (last_err_addr !== 32'h0002_0008) begin failures++; $display("FAIL to_last_err got=%h exp=00020008", last_err_addr); end
      // Ready arriving on the expiry cycle takes precedence.
      run_txn(32'h0002_000C, 32'h0, 4'h0, 1'b0, 1'b1, 2, 8, 32'hCAFE_0002, 20);
      checks++; if (got_cyc !== 9) begin failures++; $display("FAIL tie_latency got=%0d exp=9", got_cyc); end
      checks++; if (got_err !== 1'b0) begin failures++; $display("FAIL tie_error got=%0h exp=0", got_err); end
      checks++; if (got_data !== 32'hCAFE_0002) begin failures++; $display("FAIL tie_data got=%h exp=cafe0002", got_data); end
      checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL tie_err_count got=%0d exp=2", err_count); end
      // Error counter saturates.
      force dut.err_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.err_cnt_q;
      run_txn(32'h9000_0000, 32'h0, 4'h0, 1'b0, 1'b1, -1, 0, 32'h0, 10);
      checks++; if (err_count !== 16'hFFFF) begin failures++; $display("FAIL sat_err_count got=%h exp=ffff", err_count); end
      checks++; if (last_err_addr !== 32'h9000_0000) begin failures++; $display("FAIL sat_last_err got=%h exp=90000000", last_err_addr); end
   endtask

   task automatic test_overlap();
      run_txn(32'h0000_1234, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1, 32'h0BAD_F00D, 10);
      checks++; if (sn_act[1] !== 4'b0001) begin failures++; $display("FAIL ov_active got=%b exp=0001", sn_act[1]); end
      checks++; if (sn_ren[1] !== 4'b0001) begin failures++; $display("FAIL ov_ren got=%b exp=0001", sn_ren[1]); end
      checks++; if (c1_daddr[127:96] !== 32'h0000_1234) begin failures++; $display("FAIL ov_dev3_offset got=%h exp=00001234", c1_daddr[127:96]); end
      checks++; if (got_data !== 32'h0BAD_F00D) begin failures++; $display("FAIL ov_data got=%h exp=0badf00d", got_data); end
   endtask

   task automatic test_back_to_back();
      run_txn(32'h0000_0100, 32'h0, 4'h0, 1'b0, 1'b1, 0, 1, 32'h1111_0000, 10);
      checks++; if (got_data !== 32'h1111_0000) begin failures++; $display("FAIL b2b_first_data got=%h exp=11110000", got_data); end
      run_txn(32'h0001_0200, 32'h0, 4'h0, 1'b0, 1'b1, 1, 2, 32'h2222_0001, 10);
      checks++; if (got_cyc !== 3) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=3", got_cyc); end
      checks++; if (got_data !== 32'h2222_0001) begin failures++; $display("FAIL b2b_second_data got=%h exp=22220001", got_data); end
   endtask

   task automatic test_reset_mid();
      logic saw_ready;
      host_address = 32'h0001_0000;
      host_ren     = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (device_ren !== 4'b0010) begin failures++; $display("FAIL rm_busy_ren got=%b exp=0010", device_ren); end
      rst      = 1'b1;
      host_ren = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({device_ren, device_active, host_ready} !== 9'h0) begin failures++; $display("FAIL rm_outputs got=%h exp=0", {device_ren, device_active, host_ready}); end
      checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL rm_err_count got=%h exp=0", err_count); end
      device_ready[1] = 1'b1;
      device_data_read[63:32] = 32'h4444_4444;
      saw_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (host_ready !== 1'b0) saw_ready = 1'b1;
      end
      device_ready = '0;
      checks++; if (saw_ready !== 1'b0) begin failures++; $display("FAIL rm_stray_ready got=%0h exp=0", saw_ready); end
      run_txn(32'h0001_0040, 32'h0, 4'h0, 1'b0, 1'b1, 1, 2, 32'h7777_0001, 10);
      checks++; if (got_cyc !== 3) begin failures++; $display("FAIL rm_next_latency got=%0d exp=3", got_cyc); end
      checks++; if (got_data !== 32'h7777_0001) begin failures++; $display("FAIL rm_next_data got=%h exp=77770001", got_data); end
      checks++; if (sn_act[1] !== 4'b0010) begin failures++; $display("FAIL rm_next_active got=%b exp=0010", sn_act[1]); end
   endtask

   initial begin
      rst              = 1'b1;
      host_address     = '0;
      host_data_write  = '0;
      host_write_mask  = '0;
      host_wen         = 1'b0;
      host_ren         = 1'b0;
      device_ready     = '0;
      device_data_read = '0;
      noise            = '0;
      @(negedge clk);
      test_reset();
      test_read_wait();
      test_write();
      test_unmapped();
      test_timeout();
      test_overlap();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
